// File: rtl/romulus_pkg.sv
// rtl/romulus_pkg.sv - shared types, constants and the G byte function for the rho stream unit
// Contents: fsm_t (IDLE/ABSORB/PAD/CORE), BLK_BYTES, g_byte().
package romulus_pkg;

   localparam int BLK_BYTES = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ABSORB = 2'd1,
      PAD    = 2'd2,
      CORE   = 2'd3
   } fsm_t;

   // Romulus G on one state byte: rotate right by one, with bit 7 picking up s[0]^s[7].
   function automatic logic [7:0] g_byte(input logic [7:0] s);
      return {s[0] ^ s[7], s[7:1]};
   endfunction

endpackage

// File: rtl/romulus_rho_stream_if.sv
// rtl/romulus_rho_stream_if.sv - pdi/pdo word stream bundle for the rho stream unit
// Ports (signals): pdi_data/pdi_valid/pdi_ready/pdi_last/pdi_bytes input stream,
// pdo_data/pdo_valid/pdo_ready/pdo_bytes output stream.
// master = stream source/sink outside the unit, slave = the rho unit.
interface romulus_rho_stream_if #(
   parameter int DW = 32
);
   localparam int BBW = $clog2(DW / 8) + 1;

   logic [DW-1:0]  pdi_data;
   logic           pdi_valid;
   logic           pdi_ready;
   logic           pdi_last;
   logic [BBW-1:0] pdi_bytes;

   logic [DW-1:0]  pdo_data;
   logic           pdo_valid;
   logic           pdo_ready;
   logic [BBW-1:0] pdo_bytes;

   modport master (
      output pdi_data, pdi_valid, pdi_last, pdi_bytes, pdo_ready,
      input  pdi_ready, pdo_data, pdo_valid, pdo_bytes
   );

   modport slave (
      input  pdi_data, pdi_valid, pdi_last, pdi_bytes, pdo_ready,
      output pdi_ready, pdo_data, pdo_valid, pdo_bytes
   );
endinterface

// File: rtl/rho_lane.sv
// rtl/rho_lane.sv - one byte lane of rho: enc/dec select, G, padding insert (combinational)
// Ports: s = current state byte, d = input byte, dec = decrypt, valid = lane carries data,
// pad_here = lane is block byte 15, pad_len = block length byte,
// c = output byte (0 when invalid), ins = byte written back into the state.
module rho_lane
   import romulus_pkg::*;
(
   input  logic [7:0] s,
   input  logic [7:0] d,
   input  logic       dec,
   input  logic       valid,
   input  logic       pad_here,
   input  logic [7:0] pad_len,
   output logic [7:0] c,
   output logic [7:0] ins
);
   logic [7:0] g;
   logic [7:0] m;

   always_comb begin
      g = g_byte(s);
      c = '0;
      m = '0;
      if (valid) begin
         // Output is input ^ G in both modes: ciphertext on encrypt, plaintext on decrypt.
         c = d ^ g;
         m = dec ? c : d;
      end else if (pad_here) begin
         m = pad_len;
      end
      ins = s ^ m;
   end
endmodule

// File: rtl/romulus_rho_stream.sv
// rtl/romulus_rho_stream.sv - word-serial Romulus rho / state-update unit with padding and core hand-off
// Ports: clk, rst (async active-low); blk_start/blk_dec/blk_nocore/blk_empty block control;
// io = pdi/pdo streams; core_start/core_done/skinny_state SKINNY hand-off;
// state = internal 128-bit state; busy = FSM not in IDLE.
module romulus_rho_stream
   import romulus_pkg::*;
#(
   parameter int DW = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   blk_start,
   input  logic                   blk_dec,
   input  logic                   blk_nocore,
   input  logic                   blk_empty,
   romulus_rho_stream_if.slave    io,
   output logic                   core_start,
   input  logic                   core_done,
   input  logic [127:0]           skinny_state,
   output logic [127:0]           state,
   output logic                   busy
);
   localparam int NW  = 128 / DW;
   localparam int BW  = DW / 8;
   localparam int BBW = $clog2(BW) + 1;
   localparam int CW  = (NW > 1) ? $clog2(NW) : 1;

   if (!(DW == 8 || DW == 32 || DW == 64 || DW == 128)) begin : g_bad_dw
      $error("romulus_rho_stream: DW must be 8, 32, 64 or 128");
   end

   fsm_t           fsm_q, fsm_d;
   logic [127:0]   state_q;
   logic [CW-1:0]  wcnt_q;
   logic [4:0]     cnt_q;
   logic           dec_q;
   logic           nocore_q;

   logic           accept;
   logic           step;
   logic           last_word;
   logic [BBW-1:0] bytes_eff;
   logic [4:0]     pad_len;
   logic [DW-1:0]  cw;
   logic [DW-1:0]  c_word;
   logic [DW-1:0]  ins_word;
   logic [127:0]   state_step;

   assign cw        = state_q[127 -: DW];
   assign bytes_eff = io.pdi_last ? io.pdi_bytes : BBW'(BW);
   assign last_word = (wcnt_q == CW'(NW - 1));
   assign io.pdi_ready = (fsm_q == ABSORB) && (!io.pdo_valid || io.pdo_ready);
   assign accept    = io.pdi_valid && io.pdi_ready;
   assign step      = accept || (fsm_q == PAD);
   // Length byte only matters on a partial last word or in PAD, where cnt_q is already final.
   assign pad_len   = cnt_q + (accept ? 5'(bytes_eff) : 5'd0);
   // For DW=128 the shift clears everything and the new word is the whole state.
   assign state_step = (state_q << DW) | 128'(ins_word);

   for (genvar j = 0; j < BW; j++) begin : g_lane
      rho_lane u_lane (
         .s        (cw[DW-1-8*j -: 8]),
         .d        (io.pdi_data[DW-1-8*j -: 8]),
         .dec      (dec_q),
         .valid    (accept && (int'(bytes_eff) > j)),
         .pad_here ((int'(wcnt_q) * BW + j) == (BLK_BYTES - 1)),
         .pad_len  ({3'b000, pad_len}),
         .c        (c_word[DW-1-8*j -: 8]),
         .ins      (ins_word[DW-1-8*j -: 8])
      );
   end

   always_comb begin
      fsm_d = fsm_q;
      case (fsm_q)
         IDLE: begin
            if (blk_start) fsm_d = blk_empty ? PAD : ABSORB;
         end
         ABSORB: begin
            if (accept) begin
               // Word NW-1 always ends the block, with or without pdi_last.
               if (last_word)        fsm_d = nocore_q ? IDLE : CORE;
               else if (io.pdi_last) fsm_d = PAD;
            end
         end
         PAD: begin
            if (last_word) fsm_d = nocore_q ? IDLE : CORE;
         end
         CORE: begin
            if (core_done) fsm_d = IDLE;
         end
         default: fsm_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fsm_q        <= IDLE;
         state_q      <= '0;
         wcnt_q       <= '0;
         cnt_q        <= '0;
         dec_q        <= 1'b0;
         nocore_q     <= 1'b0;
         core_start   <= 1'b0;
         io.pdo_valid <= 1'b0;
         io.pdo_data  <= '0;
         io.pdo_bytes <= '0;
      end else begin
         fsm_q      <= fsm_d;
         core_start <= (fsm_d == CORE) && (fsm_q != CORE);

         if (fsm_q == IDLE && blk_start) begin
            dec_q    <= blk_dec;
            nocore_q <= blk_nocore;
            wcnt_q   <= '0;
            cnt_q    <= '0;
         end

         if (step) begin
            state_q <= state_step;
            wcnt_q  <= last_word ? '0 : wcnt_q + CW'(1);
         end

         if (fsm_q == CORE && core_done) state_q <= skinny_state;

         if (accept) begin
            cnt_q        <= cnt_q + 5'(bytes_eff);
            io.pdo_valid <= 1'b1;
            io.pdo_data  <= c_word;
            io.pdo_bytes <= bytes_eff;
         end else if (io.pdo_ready) begin
            io.pdo_valid <= 1'b0;
         end
      end
   end

   assign state = state_q;
   assign busy  = (fsm_q != IDLE);
endmodule

// File: doc/romulus_rho_stream.md
Name: romulus_rho_stream

Overview:
- Word-serial Romulus rho/state-update unit, generalised from the fixed 32-bit version to a parametrised datapath width.
- Absorbs one 128-bit block over 128/DW beats with valid/ready handshakes on input and output.
- Applies rho: output C = M xor G(S), state S' = S xor M, with decrypt handled per byte lane.
- Pads partial and empty blocks internally, hands the state to the SKINNY core, and reloads the state when the core finishes.

Parameters:
DW, 32, datapath width in bits; legal values 8, 32, 64, 128 (elaboration error otherwise)
NW, 128/DW, words per block (derived; not overridable)
BW, DW/8, byte lanes per word (derived)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
blk_start  in  1  single-cycle pulse in IDLE that begins a block
blk_dec  in  1  sampled at blk_start; 1 = decrypt block
blk_nocore  in  1  sampled at blk_start; 1 = skip the core call (tag/final block)
blk_empty  in  1  sampled at blk_start; 1 = zero-length block, go directly to PAD
pdi_data  in  DW  input word; byte 0 of the block is pdi_data[DW-1:DW-8] of word 0
pdi_valid  in  1  input word valid
pdi_ready  out  1  input word accepted when pdi_valid && pdi_ready
pdi_last  in  1  final input word of the block
pdi_bytes  in  $clog2(BW)+1  valid bytes in the word, 1..BW; only meaningful with pdi_last
pdo_data  out  DW  output word; invalid byte lanes are forced to 0
pdo_valid  out  1  output word valid
pdo_ready  in  1  downstream ready
pdo_bytes  out  $clog2(BW)+1  valid bytes in pdo_data
core_start  out  1  single-cycle pulse starting SKINNY
core_done  in  1  single-cycle pulse from SKINNY
skinny_state  in  128  core result, loaded on core_done
state  out  128  current internal state
busy  out  1  high in every FSM state except IDLE

Behaviour:
- Reset values: state=0, FSM=IDLE, pdo_valid=0, pdo_data=0, pdo_bytes=0, core_start=0, word counter=0, byte count=0, busy=0. Reset mid-block aborts the block; no further pdo or core_start is issued.
- G, per state byte s: g = {s[0]^s[7], s[7:1]}.
- Current word: cw = state[127:128-DW]. Each absorbed word shifts state left by DW and inserts the new word at state[DW-1:0], so after NW words the state is realigned.
- Encrypt, per valid byte lane: M = pdi byte, C = M ^ G(cw byte).
- Decrypt, per valid byte lane: C = pdi byte, M = C ^ G(cw byte).
- Inserted word = cw ^ M.
- Padding: invalid lanes and PAD-generated words use M=0. Block byte 15 uses M = total valid byte count (0..15) if the block is partial. A full 16-byte block is unpadded.
- FSM states:
  - IDLE: waits for blk_start. Goes to PAD if blk_empty, otherwise to ABSORB.
  - ABSORB: pdi_ready = !pdo_valid || pdo_ready. Each accepted word registers pdo_data and pdo_bytes, and sets pdo_valid the next cycle (latency 1).
    - pdi_last on word NW-1 goes to CORE, or to IDLE if nocore.
    - pdi_last on an earlier word, or a word with pdi_bytes<BW, goes to PAD.
    - If word NW-1 arrives without pdi_last, it is treated as last.
  - PAD: inserts the remaining words at one per cycle with no handshake and no pdo. Then goes to CORE, or to IDLE if nocore.
  - CORE: core_start pulses on the first cycle. The FSM waits for core_done, loads state <= skinny_state, and returns to IDLE.
- pdo handshake: pdo_data is held stable while pdo_valid && !pdo_ready. pdo_valid may remain set into IDLE or CORE until drained.
- blk_start outside IDLE is ignored.
- core_done outside CORE is ignored.
- core_done in the same cycle as core_start is honoured.
- Simultaneous drain and accept in ABSORB gives full throughput of one word per cycle.
- For DW=128 there is a single word and the word counter is unused.

Decomposition:
- Package romulus_pkg:
  - FSM enum (IDLE, ABSORB, PAD, CORE)
  - function g_byte
  - constant BLK_BYTES=16
- Sub-module rho_lane: one byte lane, purely combinational (enc/dec select, G, pad insert), instantiated BW times via generate.

Test Plan:
- DW=32, encrypt, S=0, M=00112233_44556677_8899AABB_CCDDEEFF full block, nocore -> C equals M; state equals M; IDLE 1 cycle after pdo of word 3.
- DW=32, S=80808080_..., encrypt, M all 00 -> every pdo byte is G(80)=C0; core_start pulses once; core_done with skinny_state=DEADBEEF_... -> state loaded with that value.
- DW=8, partial block of 5 bytes 01..05, S=0 -> 5 pdo beats with values 01..05, then 11 PAD cycles with no pdo; state byte 15 = 05, bytes 5..14 = 00.
- DW=64, decrypt round-trip: encrypt a random M under random S, then decrypt the resulting C under the same S -> pdo equals M and both final states match.
- blk_empty with DW=32 -> no pdo; 4 PAD cycles; state equals the original S, since M is all-zero with length byte 00; core_start pulses.
- pdo_ready held low for 3 cycles mid-block, and reset asserted in CORE -> data held and pdi_ready=0 while stalled; after reset all outputs are 0 and no core_start follows.
